// File: rtl/reg_wr_arbiter_pkg.sv
// Shared constants and types for the reg_file write-port arbiter.
package reg_wr_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    // Register x0 is hardwired to zero; writes to it are dropped.
    localparam logic [AW-1:0] REG_ZERO = '0;

    // Identity of the source that last won the write port.
    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Writeback request bundle for the two sources sharing the reg_file write port.
interface reg_wr_arbiter_if #(
    parameter int XLEN = reg_wr_arbiter_pkg::XLEN,
    parameter int AW   = reg_wr_arbiter_pkg::AW
);
    import reg_wr_arbiter_pkg::*;

    logic            a_valid;
    logic [AW-1:0]   a_rd;
    logic [XLEN-1:0] a_data;
    logic            a_ready;

    logic            b_valid;
    logic [AW-1:0]   b_rd;
    logic [XLEN-1:0] b_data;
    logic            b_ready;

    // Writeback sources drive requests and watch ready.
    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  a_ready, b_ready
    );

    // The arbiter consumes requests and returns ready.
    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output a_ready, b_ready
    );

endinterface

// File: rtl/reg_wr_arbiter_rr_arb2.sv
// Two-request round-robin arbiter; on a tie the source not served last wins.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);
    import reg_wr_arbiter_pkg::*;

    grant_e last_grant_q;
    grant_e last_grant_d;

    // Grant the sole requester, or alternate on contention.
    always_comb begin
        gnt_a        = req_a && (!req_b || (last_grant_q == GNT_B));
        gnt_b        = req_b && (!req_a || (last_grant_q == GNT_A));
        last_grant_d = last_grant_q;
        if (gnt_a) begin
            last_grant_d = GNT_A;
        end else if (gnt_b) begin
            last_grant_d = GNT_B;
        end
    end

    // Reset to B so the first tie after reset goes to A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Shares the reg_file write port between ALU (A) and load unit (B) writeback,
// stages the granted write for one cycle and forwards it to both read ports.
module reg_wr_arbiter #(
    parameter int XLEN  = reg_wr_arbiter_pkg::XLEN,
    parameter int AW    = reg_wr_arbiter_pkg::AW,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_wr_arbiter_if.slave  wb,
    output logic             rf_write,
    output logic [AW-1:0]    rf_rd,
    output logic [XLEN-1:0]  rf_write_data,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [XLEN-1:0]  rf_out1,
    input  logic [XLEN-1:0]  rf_out2,
    output logic [XLEN-1:0]  out1,
    output logic [XLEN-1:0]  out2,
    output logic [CNT_W-1:0] conflict_cnt
);
    import reg_wr_arbiter_pkg::*;

    logic             live_a;
    logic             live_b;
    logic             gnt_a;
    logic             gnt_b;

    logic             rf_write_q, rf_write_d;
    logic [AW-1:0]    rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]  rf_write_data_q, rf_write_data_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Read-port bypass: x0 reads zero, a staged write to the same register wins.
    function automatic logic [XLEN-1:0] fwd(
        input logic [AW-1:0]   rs,
        input logic [XLEN-1:0] rf_out,
        input logic            st_write,
        input logic [AW-1:0]   st_rd,
        input logic [XLEN-1:0] st_data
    );
        if (rs == REG_ZERO) begin
            return '0;
        end
        if (st_write && (st_rd == rs)) begin
            return st_data;
        end
        return rf_out;
    endfunction

    // x0 writes never compete for the port; only live requests reach the arbiter.
    assign live_a = wb.a_valid && (wb.a_rd != REG_ZERO);
    assign live_b = wb.b_valid && (wb.b_rd != REG_ZERO);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_a (live_a),
        .req_b (live_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    // x0 requests are acknowledged immediately and silently dropped.
    assign wb.a_ready = gnt_a || (wb.a_valid && (wb.a_rd == REG_ZERO));
    assign wb.b_ready = gnt_b || (wb.b_valid && (wb.b_rd == REG_ZERO));

    // Load the staging register with the winner; hold address/data when idle.
    always_comb begin
        rf_write_d      = gnt_a || gnt_b;
        rf_rd_d         = rf_rd_q;
        rf_write_data_d = rf_write_data_q;
        conflict_cnt_d  = conflict_cnt_q;
        if (gnt_a) begin
            rf_rd_d         = wb.a_rd;
            rf_write_data_d = wb.a_data;
        end else if (gnt_b) begin
            rf_rd_d         = wb.b_rd;
            rf_write_data_d = wb.b_data;
        end
        if (live_a && live_b) begin
            conflict_cnt_d = sat_inc(conflict_cnt_q);
        end
    end

    // Reset clears the stage so an in-flight write never reaches reg_file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_q      <= 1'b0;
            rf_rd_q         <= '0;
            rf_write_data_q <= '0;
            conflict_cnt_q  <= '0;
        end else begin
            rf_write_q      <= rf_write_d;
            rf_rd_q         <= rf_rd_d;
            rf_write_data_q <= rf_write_data_d;
            conflict_cnt_q  <= conflict_cnt_d;
        end
    end

    assign rf_write      = rf_write_q;
    assign rf_rd         = rf_rd_q;
    assign rf_write_data = rf_write_data_q;
    assign conflict_cnt  = conflict_cnt_q;

    assign out1 = fwd(rs1, rf_out1, rf_write_q, rf_rd_q, rf_write_data_q);
    assign out2 = fwd(rs2, rf_out2, rf_write_q, rf_rd_q, rf_write_data_q);

endmodule
